store_buffer: RTL and testbench

Parametrised Wishbone store unit with a posted-write buffer, sitting between the CPU execute stage and the data bus. It accepts byte, half and word stores through a valid/ready handshake and queues up to DEPTH of them. It drains the queue as single big-endian lane-selected Wishbone write cycles. It adds misalignment rejection, a bus timeout and error-address capture.

---
 rtl/store_buffer_if.sv | 30 +++
 rtl/store_buffer.sv | 173 +++++++++++++++++
 tb/tb_store_buffer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store-request handshake plus Wishbone write bus for store_buffer.
// slave = the store unit; master = the CPU side and the bus responder.
interface store_buffer_if #(
   parameter int DATA_W = 32
);
   localparam int NB = DATA_W / 8;

   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_size;
   logic [31:0]       req_addr;
   logic [31:0]       req_data;
   logic [31:0]       wb_addr;
   logic              wb_cyc;
   logic [NB-1:0]     wb_stb;
   logic              wb_we;
   logic [DATA_W-1:0] wb_dat;
   logic              wb_ack;
   logic              wb_err;

   modport master (
      output req_valid, req_size, req_addr, req_data, wb_ack, wb_err,
      input  req_ready, wb_addr, wb_cyc, wb_stb, wb_we, wb_dat
   );

   modport slave (
      input  req_valid, req_size, req_addr, req_data, wb_ack, wb_err,
      output req_ready, wb_addr, wb_cyc, wb_stb, wb_we, wb_dat
   );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues byte/half/word stores and drains them
// as single big-endian lane-selected Wishbone write cycles.
module store_buffer #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   store_buffer_if.slave              bus,
   output logic                       o_done,
   output logic                       o_error,
   output logic [31:0]                o_err_addr,
   output logic                       o_misalign,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);
   localparam int NB = DATA_W / 8;
   localparam int KW = $clog2(NB);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {IDLE, BUS} state_t;

   logic [31:0] addr_mem [DEPTH];
   logic [1:0]  size_mem [DEPTH];
   logic [31:0] data_mem [DEPTH];

   state_t            state_reg;
   logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]     count_reg, count_next;
   logic              ready_reg;
   logic [31:0]       tmo_cnt_reg;
   logic [31:0]       cur_addr_reg;
   logic [31:0]       wb_addr_reg;
   logic              wb_cyc_reg;
   logic [NB-1:0]     wb_stb_reg;
   logic [DATA_W-1:0] wb_dat_reg;

   logic              req_fire, misaligned, push, pop, tmo_hit, fail;
   logic [31:0]       head_addr, head_data;
   logic [1:0]        head_size;
   logic [KW-1:0]     head_lane;
   logic [NB-1:0]     stb_base, head_stb;
   logic [DATA_W-1:0] dat_b, dat_h, dat_w, head_dat;

   assign bus.req_ready = ready_reg & i_reset_n;
   assign bus.wb_addr   = wb_addr_reg;
   assign bus.wb_cyc    = wb_cyc_reg;
   assign bus.wb_we     = wb_cyc_reg;
   assign bus.wb_stb    = wb_stb_reg;
   assign bus.wb_dat    = wb_dat_reg;
   assign o_count       = count_reg;

   assign req_fire   = bus.req_valid && bus.req_ready && (bus.req_size != 2'b00);
   assign misaligned = ((bus.req_size == 2'b10) && bus.req_addr[0]) ||
                       ((bus.req_size == 2'b11) && (bus.req_addr[1:0] != 2'b00));
   assign push       = req_fire && !misaligned;

   // Abort is a plain timeout only when the responder stays silent that edge.
   assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_reg == 32'(TIMEOUT - 1));
   assign fail    = bus.wb_err || (!bus.wb_ack && tmo_hit);
   assign pop     = (state_reg == BUS) && (bus.wb_ack || bus.wb_err || tmo_hit);

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   assign head_addr = addr_mem[rd_ptr_reg];
   assign head_size = size_mem[rd_ptr_reg];
   assign head_data = data_mem[rd_ptr_reg];
   assign head_lane = head_addr[KW-1:0];

   genvar gi;
   for (gi = 0; gi < NB; gi++) begin : g_rep_b
      assign dat_b[gi*8 +: 8] = head_data[7:0];
   end
   for (gi = 0; gi < NB / 2; gi++) begin : g_rep_h
      assign dat_h[gi*16 +: 16] = head_data[15:0];
   end
   for (gi = 0; gi < NB / 4; gi++) begin : g_rep_w
      assign dat_w[gi*32 +: 32] = head_data;
   end

   // Lane NB-1 holds the lowest address; shifting right by k walks toward higher addresses.
   always_comb begin
      stb_base = '0;
      head_dat = dat_w;
      case (head_size)
         2'b01: begin
            stb_base = NB'(1) << (NB - 1);
            head_dat = dat_b;
         end
         2'b10: begin
            stb_base = NB'(3) << (NB - 2);
            head_dat = dat_h;
         end
         2'b11: stb_base = NB'(15) << (NB - 4);
         default: stb_base = '0;
      endcase
      head_stb = stb_base >> head_lane;
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         addr_mem[wr_ptr_reg] <= bus.req_addr;
         size_mem[wr_ptr_reg] <= bus.req_size;
         data_mem[wr_ptr_reg] <= bus.req_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_reg    <= IDLE;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         ready_reg    <= 1'b0;
         tmo_cnt_reg  <= '0;
         cur_addr_reg <= '0;
         wb_addr_reg  <= '0;
         wb_cyc_reg   <= 1'b0;
         wb_stb_reg   <= '0;
         wb_dat_reg   <= '0;
         o_done       <= 1'b0;
         o_error      <= 1'b0;
         o_err_addr   <= '0;
         o_misalign   <= 1'b0;
      end else begin
         o_done     <= 1'b0;
         o_error    <= 1'b0;
         o_misalign <= req_fire && misaligned;
         count_reg  <= count_next;
         ready_reg  <= (count_next != CW'(DEPTH));
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;

         case (state_reg)
            IDLE: begin
               if (count_reg != '0) begin
                  cur_addr_reg <= head_addr;
                  wb_addr_reg  <= {head_addr[31:KW], KW'(0)};
                  wb_stb_reg   <= head_stb;
                  wb_dat_reg   <= head_dat;
                  wb_cyc_reg   <= 1'b1;
                  tmo_cnt_reg  <= '0;
                  state_reg    <= BUS;
               end
            end
            BUS: begin
               if (pop) begin
                  wb_cyc_reg <= 1'b0;
                  wb_stb_reg <= '0;
                  state_reg  <= IDLE;
                  if (fail) begin
                     o_error    <= 1'b1;
                     o_err_addr <= cur_addr_reg;
                  end else begin
                     o_done <= 1'b1;
                  end
               end else if (TIMEOUT != 0) begin
                  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a 32-bit instance (TIMEOUT=8) and a
// 64-bit instance, driven by one linear sequence of steps.
module tb_store_buffer;
   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   int   n_done, seen, idle;
   logic fire;

   always #5 clk = ~clk;

   store_buffer_if #(.DATA_W(32)) bus_a ();
   store_buffer_if #(.DATA_W(64)) bus_b ();

   logic        done_a, error_a, mis_a, done_b, error_b, mis_b;
   logic [31:0] eaddr_a, eaddr_b;
   logic [2:0]  count_a, count_b;

   store_buffer #(.DATA_W(32), .DEPTH(4), .TIMEOUT(8)) u_a (
      .i_clk(clk), .i_reset_n(rst_n), .bus(bus_a),
      .o_done(done_a), .o_error(error_a), .o_err_addr(eaddr_a),
      .o_misalign(mis_a), .o_count(count_a)
   );

   store_buffer #(.DATA_W(64), .DEPTH(4), .TIMEOUT(255)) u_b (
      .i_clk(clk), .i_reset_n(rst_n), .bus(bus_b),
      .o_done(done_b), .o_error(error_b), .o_err_addr(eaddr_b),
      .o_misalign(mis_b), .o_count(count_b)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_a(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
      bus_a.req_valid = 1'b1;
      bus_a.req_size  = size;
      bus_a.req_addr  = addr;
      bus_a.req_data  = data;
   endtask

   task automatic set_b(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
      bus_b.req_valid = 1'b1;
      bus_b.req_size  = size;
      bus_b.req_addr  = addr;
      bus_b.req_data  = data;
   endtask

   initial begin
      rst_n = 1'b0;
      bus_a.req_valid = 1'b0; bus_a.req_size = 2'b00; bus_a.req_addr = '0; bus_a.req_data = '0;
      bus_a.wb_ack = 1'b0; bus_a.wb_err = 1'b0;
      bus_b.req_valid = 1'b0; bus_b.req_size = 2'b00; bus_b.req_addr = '0; bus_b.req_data = '0;
      bus_b.wb_ack = 1'b0; bus_b.wb_err = 1'b0;
      tick; tick;
      check("rst_cyc", bus_a.wb_cyc, 0);
      check("rst_ready", bus_a.req_ready, 0);
      check("rst_count", count_a, 0);
      check("rst_pulses", {done_a, error_a, mis_a}, 0);
      check("rst_err_addr", eaddr_a, 0);
      rst_n = 1'b1;
      tick;
      check("ready_after_rst", bus_a.req_ready, 1);

      // Byte store, 32-bit bus
      set_a(2'b01, 32'h1001, 32'hAB);
      tick;
      bus_a.req_valid = 1'b0;
      check("t1_count", count_a, 1);
      check("t1_cyc_early", bus_a.wb_cyc, 0);
      tick;
      check("t1_cyc", bus_a.wb_cyc, 1);
      check("t1_we", bus_a.wb_we, 1);
      check("t1_addr", bus_a.wb_addr, 32'h1000);
      check("t1_stb", bus_a.wb_stb, 4'b0100);
      check("t1_dat", bus_a.wb_dat, 32'hABABABAB);
      tick;
      check("t1_cyc_hold", bus_a.wb_cyc, 1);
      check("t1_no_done", done_a, 0);
      bus_a.wb_ack = 1'b1;
      tick;
      bus_a.wb_ack = 1'b0;
      check("t1_done", done_a, 1);
      check("t1_cyc_low", bus_a.wb_cyc, 0);
      check("t1_count0", count_a, 0);
      tick;
      check("t1_done_pulse", done_a, 0);

      // Half and word stores, 64-bit bus
      set_b(2'b10, 32'h2006, 32'h1234);
      tick;
      bus_b.req_valid = 1'b0;
      tick;
      check("t2h_cyc", bus_b.wb_cyc, 1);
      check("t2h_addr", bus_b.wb_addr, 32'h2000);
      check("t2h_stb", bus_b.wb_stb, 8'h03);
      check("t2h_dat", bus_b.wb_dat, 64'h1234123412341234);
      bus_b.wb_ack = 1'b1;
      tick;
      bus_b.wb_ack = 1'b0;
      check("t2h_done", done_b, 1);
      set_b(2'b11, 32'h2000, 32'hDEADBEEF);
      tick;
      bus_b.req_valid = 1'b0;
      tick;
      check("t2w_stb", bus_b.wb_stb, 8'hF0);
      check("t2w_dat", bus_b.wb_dat, 64'hDEADBEEFDEADBEEF);
      bus_b.wb_ack = 1'b1;
      tick;
      bus_b.wb_ack = 1'b0;
      check("t2w_done", done_b, 1);
      check("t2w_count", count_b, 0);

      // Fill to DEPTH with ack low; fifth request stalls
      for (int i = 0; i < 4; i++) begin
         set_a(2'b11, 32'h100 + 32'(4 * i), 32'h11111111 * 32'(i + 1));
         tick;
      end
      check("t3_full_count", count_a, 4);
      check("t3_full_ready", bus_a.req_ready, 0);
      set_a(2'b11, 32'h110, 32'h55555555);
      tick;
      check("t3_stall_count", count_a, 4);
      check("t3_stall_ready", bus_a.req_ready, 0);
      n_done = 0; seen = 0; idle = 0;
      for (int c = 0; c < 40 && n_done < 5; c++) begin
         if (bus_a.wb_cyc) begin
            check($sformatf("t3_addr%0d", seen), bus_a.wb_addr, 32'h100 + 32'(4 * seen));
            if (seen > 0) check("t3_gap", idle, 1);
            seen++;
            idle = 0;
            bus_a.wb_ack = 1'b1;
         end else begin
            idle++;
            bus_a.wb_ack = 1'b0;
         end
         if (done_a) n_done++;
         fire = bus_a.req_valid && bus_a.req_ready;
         tick;
         if (fire) bus_a.req_valid = 1'b0;
      end
      bus_a.wb_ack = 1'b0;
      bus_a.req_valid = 1'b0;
      check("t3_n_done", n_done, 5);
      check("t3_n_cycles", seen, 5);
      check("t3_count_end", count_a, 0);

      // Misaligned half and word
      set_a(2'b10, 32'h3001, 32'h9999);
      tick;
      bus_a.req_valid = 1'b0;
      check("t4h_mis", mis_a, 1);
      check("t4h_count", count_a, 0);
      tick;
      check("t4h_mis_pulse", mis_a, 0);
      check("t4h_no_cyc", bus_a.wb_cyc, 0);
      set_a(2'b11, 32'h3002, 32'h77777777);
      tick;
      bus_a.req_valid = 1'b0;
      check("t4w_mis", mis_a, 1);
      check("t4w_count", count_a, 0);
      tick;
      check("t4w_no_cyc", bus_a.wb_cyc, 0);

      // ack and err together: err wins
      set_a(2'b11, 32'h4004, 32'hCAFEF00D);
      tick;
      bus_a.req_valid = 1'b0;
      tick;
      check("t5_cyc", bus_a.wb_cyc, 1);
      bus_a.wb_ack = 1'b1;
      bus_a.wb_err = 1'b1;
      tick;
      bus_a.wb_ack = 1'b0;
      bus_a.wb_err = 1'b0;
      check("t5_error", error_a, 1);
      check("t5_no_done", done_a, 0);
      check("t5_err_addr", eaddr_a, 32'h4004);
      check("t5_cyc_low", bus_a.wb_cyc, 0);
      tick;
      check("t5_err_pulse", error_a, 0);

      // Timeout with TIMEOUT=8
      set_a(2'b01, 32'h5003, 32'h5A);
      tick;
      bus_a.req_valid = 1'b0;
      tick;
      check("t6_cyc_rose", bus_a.wb_cyc, 1);
      for (int i = 0; i < 7; i++) tick;
      check("t6_cyc_still", bus_a.wb_cyc, 1);
      check("t6_no_err_yet", error_a, 0);
      tick;
      check("t6_error", error_a, 1);
      check("t6_cyc_low", bus_a.wb_cyc, 0);
      check("t6_err_addr", eaddr_a, 32'h5003);
      check("t6_no_done", done_a, 0);

      // Reset mid-BUS with three entries queued
      tick;
      for (int i = 0; i < 3; i++) begin
         set_a(2'b11, 32'h600 + 32'(4 * i), 32'hA0A0A0A0);
         tick;
      end
      bus_a.req_valid = 1'b0;
      check("t7_count3", count_a, 3);
      check("t7_cyc", bus_a.wb_cyc, 1);
      rst_n = 1'b0;
      tick;
      check("t7_cyc_drop", bus_a.wb_cyc, 0);
      check("t7_count0", count_a, 0);
      check("t7_pulses", {done_a, error_a}, 0);
      check("t7_ready_rst", bus_a.req_ready, 0);
      rst_n = 1'b1;
      tick;
      check("t7_ready", bus_a.req_ready, 1);
      tick; tick;
      check("t7_idle_cyc", bus_a.wb_cyc, 0);
      check("t7_idle_count", count_a, 0);
      check("t7_idle_pulses", {done_a, error_a}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
